// File: rtl/ysyx_041514_alu_div_slow_if.sv
// Request/result bundle between the EXU and the iterative divider.
// The requester holds div_valid_i high for the whole operation and
// the divider answers with a one-cycle div_ready_o pulse.
interface ysyx_041514_alu_div_slow_if #(
   parameter int XLEN = 64
);
   logic            div_signed_valid_i;
   logic [XLEN-1:0] dividend_i;
   logic [XLEN-1:0] divisor_i;
   logic            div_valid_i;
   logic            div_ready_o;
   logic [XLEN-1:0] quotient_o;
   logic [XLEN-1:0] remainder_o;

   modport master (
      output div_signed_valid_i,
      output dividend_i,
      output divisor_i,
      output div_valid_i,
      input  div_ready_o,
      input  quotient_o,
      input  remainder_o
   );

   modport slave (
      input  div_signed_valid_i,
      input  dividend_i,
      input  divisor_i,
      input  div_valid_i,
      output div_ready_o,
      output quotient_o,
      output remainder_o
   );
endinterface

// File: rtl/ysyx_041514_alu_div_slow.sv
// Iterative restoring divider, one quotient bit per cycle, serving
// DIV/DIVU/REM/REMU. Quotient and remainder are produced together.
//
// Optional feature macro: YSYX_041514_DIV_EARLY_OUT_EN
//   defined   : divide-by-zero and signed overflow are answered directly
//               from IDLE, ready one cycle after acceptance.
//   undefined : special cases run the full iteration and are overridden
//               at the finish step. Results are identical either way.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_RST  | one cycle after reset, ignores requests
// ST_IDLE | waiting for div_valid_i, clears ready and step counter
// ST_CALC | one restoring step per cycle, finish when count == XLEN
module ysyx_041514_alu_div_slow #(
   parameter int XLEN = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   ysyx_041514_alu_div_slow_if.slave      bus
);

   localparam int              CW         = $clog2(XLEN + 1);
   localparam logic [CW-1:0]   COUNT_LAST = CW'(XLEN);
   localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_RST,
      ST_IDLE,
      ST_CALC
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [CW-1:0]   count_r;
   logic [XLEN:0]   rem_r;
   logic [XLEN-1:0] quo_r;
   logic [XLEN-1:0] dvs_r;
   logic [XLEN-1:0] dividend_lat_r;
   logic            q_sign_r;
   logic            r_sign_r;
   logic            div_zero_r;
   logic            ovf_r;

   logic            ready_r;
   logic [XLEN-1:0] quotient_r;
   logic [XLEN-1:0] remainder_r;

   // Control strobes from the FSM
   logic            accept;
   logic            step;
   logic            finish;
   logic            early;

   // Incoming operand decode
   logic            sa_in;
   logic            sb_in;
   logic            div_zero_in;
   logic            ovf_in;
   logic            special_in;
   logic [XLEN-1:0] dividend_abs;
   logic [XLEN-1:0] divisor_abs;

   // Restoring step datapath
   logic [XLEN:0]   rem_shift;
   logic [XLEN:0]   rem_sub;
   logic            rem_ge;

   // Final result selection
   logic [XLEN-1:0] fin_q;
   logic [XLEN-1:0] fin_r;
   logic [XLEN-1:0] early_q;
   logic [XLEN-1:0] early_r;

   assign bus.div_ready_o = ready_r;
   assign bus.quotient_o  = quotient_r;
   assign bus.remainder_o = remainder_r;

   // Sign, magnitude and special-case decode of the live operands
   always_comb begin
      sa_in        = bus.div_signed_valid_i & bus.dividend_i[XLEN-1];
      sb_in        = bus.div_signed_valid_i & bus.divisor_i[XLEN-1];
      dividend_abs = sa_in ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
      divisor_abs  = sb_in ? (~bus.divisor_i + 1'b1)  : bus.divisor_i;
      div_zero_in  = (bus.divisor_i == '0);
      ovf_in       = bus.div_signed_valid_i && (bus.dividend_i == INT_MIN)
                     && (bus.divisor_i == '1);
      special_in   = div_zero_in | ovf_in;
      early_q      = div_zero_in ? '1 : bus.dividend_i;
      early_r      = div_zero_in ? bus.dividend_i : '0;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      rem_shift = {rem_r[XLEN-1:0], quo_r[XLEN-1]};
      rem_sub   = rem_shift - {1'b0, dvs_r};
      rem_ge    = (rem_shift >= {1'b0, dvs_r});
   end

   // Sign fixup with special-case override at the finish step
   always_comb begin
      fin_q = q_sign_r ? (~quo_r + 1'b1) : quo_r;
      fin_r = r_sign_r ? (~rem_r[XLEN-1:0] + 1'b1) : rem_r[XLEN-1:0];
      if (div_zero_r) begin
         fin_q = '1;
         fin_r = dividend_lat_r;
      end else if (ovf_r) begin
         fin_q = dividend_lat_r;
         fin_r = '0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RST;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and control strobes
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      early     = 1'b0;
      case (state)
         ST_RST: begin
            state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.div_valid_i) begin
`ifdef YSYX_041514_DIV_EARLY_OUT_EN
               if (special_in) begin
                  early = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = ST_CALC;
               end
`else
               accept    = 1'b1;
               state_nxt = ST_CALC;
`endif
            end
         end
         ST_CALC: begin
            // A dropped request abandons the operation, even on the last step
            if (!bus.div_valid_i) begin
               state_nxt = ST_IDLE;
            end else if (count_r == COUNT_LAST) begin
               finish    = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               step = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_RST;
         end
      endcase
   end

   // Operand latch, iteration registers and step counter
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r        <= '0;
         rem_r          <= '0;
         quo_r          <= '0;
         dvs_r          <= '0;
         dividend_lat_r <= '0;
         q_sign_r       <= 1'b0;
         r_sign_r       <= 1'b0;
         div_zero_r     <= 1'b0;
         ovf_r          <= 1'b0;
      end else begin
         if (state != ST_CALC) begin
            count_r <= '0;
         end
         if (accept) begin
            rem_r          <= '0;
            quo_r          <= dividend_abs;
            dvs_r          <= divisor_abs;
            dividend_lat_r <= bus.dividend_i;
            q_sign_r       <= sa_in ^ sb_in;
            r_sign_r       <= sa_in;
            div_zero_r     <= div_zero_in;
            ovf_r          <= ovf_in;
         end
         if (step) begin
            rem_r   <= rem_ge ? rem_sub : rem_shift;
            quo_r   <= {quo_r[XLEN-2:0], rem_ge};
            count_r <= count_r + 1'b1;
         end
      end
   end

   // Registered results and the one-cycle ready pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_r     <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
      end else begin
         ready_r <= finish | early;
         if (finish) begin
            quotient_r  <= fin_q;
            remainder_r <= fin_r;
         end else if (early) begin
            quotient_r  <= early_q;
            remainder_r <= early_r;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_041514_alu_div_slow.sv
// Self-checking bench for the iterative divider: directed cases, randomized
// operands against a plain-arithmetic reference, abort, reset and back-to-back.
module tb_ysyx_041514_alu_div_slow;

   localparam int          XLEN    = 64;
   localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ALL1    = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk;
   logic rst;

   int n_cmp;
   int n_err;

   logic [63:0] last_q;
   logic [63:0] last_r;

   ysyx_041514_alu_div_slow_if #(.XLEN(XLEN)) bus ();

   ysyx_041514_alu_div_slow #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   // RISC-V division semantics straight from the ISA rules
   function automatic void ref_div(input logic s, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] q, output logic [63:0] r);
      longint sa;
      longint sb;
      sa = a;
      sb = b;
      if (b == 64'd0) begin
         q = ALL1;
         r = a;
      end else if (s && a == INT_MIN && b == ALL1) begin
         q = a;
         r = 64'd0;
      end else if (s) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   function automatic int expected_latency(input logic s, input logic [63:0] a, input logic [63:0] b);
      int lat;
      lat = 65;
`ifdef YSYX_041514_DIV_EARLY_OUT_EN
      if (b == 64'd0 || (s && a == INT_MIN && b == ALL1)) lat = 0;
`endif
      return lat;
   endfunction

   // Drives one full request, scrambling operands during the iteration,
   // and checks latency, results and the single-cycle ready pulse
   task automatic run_op(input logic s, input logic [63:0] a, input logic [63:0] b, input string name);
      logic [63:0] eq;
      logic [63:0] er;
      int n;
      bit got;
      ref_div(s, a, b, eq, er);
      bus.div_signed_valid_i = s;
      bus.dividend_i         = a;
      bus.divisor_i          = b;
      bus.div_valid_i        = 1'b1;
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(posedge clk);
         #1;
         if (bus.div_ready_o === 1'b1) begin
            got = 1'b1;
         end else begin
            n++;
            bus.dividend_i = rand64();
            bus.divisor_i  = rand64();
         end
      end
      bus.div_valid_i = 1'b0;
      n_cmp++;
      if (!got || n != expected_latency(s, a, b)) begin
         n_err++;
         $display("FAIL %s latency: got %0d (ready seen %0d) expected %0d", name, n, got, expected_latency(s, a, b));
      end
      n_cmp++;
      if (bus.quotient_o !== eq) begin
         n_err++;
         $display("FAIL %s quotient: got %h expected %h", name, bus.quotient_o, eq);
      end
      n_cmp++;
      if (bus.remainder_o !== er) begin
         n_err++;
         $display("FAIL %s remainder: got %h expected %h", name, bus.remainder_o, er);
      end
      last_q = eq;
      last_r = er;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.div_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL %s ready_pulse_width: got %b expected 0", name, bus.div_ready_o);
      end
   endtask

   task automatic test_reset();
      rst                    = 1'b1;
      bus.div_valid_i        = 1'b0;
      bus.div_signed_valid_i = 1'b0;
      bus.dividend_i         = 64'd0;
      bus.divisor_i          = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.div_ready_o !== 1'b0 || bus.quotient_o !== 64'd0 || bus.remainder_o !== 64'd0) begin
         n_err++;
         $display("FAIL reset: got ready=%b q=%h r=%h expected 0/0/0", bus.div_ready_o, bus.quotient_o, bus.remainder_o);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      last_q = 64'd0;
      last_r = 64'd0;
   endtask

   task automatic test_directed();
      run_op(1'b0, 64'd100, 64'd7, "udiv_100_7");
      run_op(1'b1, -64'sd7, 64'd2, "sdiv_m7_2");
      run_op(1'b1, 64'd5, 64'd0, "sdiv_5_0");
      run_op(1'b1, INT_MIN, ALL1, "sdiv_overflow");
      run_op(1'b0, 64'd5, 64'd0, "udiv_5_0");
      run_op(1'b0, INT_MIN, ALL1, "udiv_min_all1");
      run_op(1'b1, 64'd7, -64'sd2, "sdiv_7_m2");
      run_op(1'b0, ALL1, 64'd1, "udiv_max_1");
   endtask

   function automatic logic [63:0] pick_operand(input bit is_divisor);
      case ($urandom_range(0, 5))
         0:       return is_divisor ? 64'd0 : INT_MIN;
         1:       return ALL1;
         2:       return 64'($urandom_range(0, 300));
         3:       return -64'($urandom_range(1, 300));
         default: return rand64();
      endcase
   endfunction

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         run_op(1'($urandom_range(0, 1)), pick_operand(1'b0), pick_operand(1'b1), "random");
      end
   endtask

   task automatic test_abort();
      bit seen;
      bus.div_signed_valid_i = 1'b0;
      bus.dividend_i         = 64'd123456;
      bus.divisor_i          = 64'd11;
      bus.div_valid_i        = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      bus.div_valid_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (bus.div_ready_o === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_err++;
         $display("FAIL abort_no_ready: got ready pulse expected none");
      end
      n_cmp++;
      if (bus.quotient_o !== last_q || bus.remainder_o !== last_r) begin
         n_err++;
         $display("FAIL abort_outputs_held: got q=%h r=%h expected q=%h r=%h", bus.quotient_o, bus.remainder_o, last_q, last_r);
      end
      run_op(1'b0, ALL1, 64'd16, "after_abort");
   endtask

   task automatic test_rst_mid_op();
      bus.div_signed_valid_i = 1'b1;
      bus.dividend_i         = 64'd12345;
      bus.divisor_i          = 64'd7;
      bus.div_valid_i        = 1'b1;
      repeat (31) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.div_ready_o !== 1'b0 || bus.quotient_o !== 64'd0 || bus.remainder_o !== 64'd0) begin
         n_err++;
         $display("FAIL rst_mid_op: got ready=%b q=%h r=%h expected 0/0/0", bus.div_ready_o, bus.quotient_o, bus.remainder_o);
      end
      rst             = 1'b0;
      bus.div_valid_i = 1'b0;
      @(posedge clk);
      #1;
      run_op(1'b0, 64'd9, 64'd3, "after_rst");
   endtask

   // Valid held through the ready cycle starts a second op with the operands present then
   task automatic test_back_to_back();
      logic [63:0] eq;
      logic [63:0] er;
      int n;
      bit got;
      bus.div_signed_valid_i = 1'b0;
      bus.dividend_i         = 64'd1000;
      bus.divisor_i          = 64'd9;
      bus.div_valid_i        = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(posedge clk);
         #1;
         if (bus.div_ready_o === 1'b1) got = 1'b1;
         else n++;
      end
      ref_div(1'b0, 64'd1000, 64'd9, eq, er);
      n_cmp++;
      if (!got || n != 65 || bus.quotient_o !== eq || bus.remainder_o !== er) begin
         n_err++;
         $display("FAIL b2b_first: got lat=%0d q=%h r=%h expected lat=65 q=%h r=%h", n, bus.quotient_o, bus.remainder_o, eq, er);
      end
      bus.div_signed_valid_i = 1'b1;
      bus.dividend_i         = -64'sd1000;
      bus.divisor_i          = 64'd7;
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(posedge clk);
         #1;
         if (bus.div_ready_o === 1'b1) got = 1'b1;
         else n++;
      end
      bus.div_valid_i = 1'b0;
      ref_div(1'b1, -64'sd1000, 64'd7, eq, er);
      n_cmp++;
      if (!got || n != 65 || bus.quotient_o !== eq || bus.remainder_o !== er) begin
         n_err++;
         $display("FAIL b2b_second: got lat=%0d q=%h r=%h expected lat=65 q=%h r=%h", n, bus.quotient_o, bus.remainder_o, eq, er);
      end
      last_q = eq;
      last_r = er;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.div_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_ready_drop: got %b expected 0", bus.div_ready_o);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      last_q = 64'd0;
      last_r = 64'd0;
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_rst_mid_op();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
